// File: rtl/image_buffer_reader.sv
// Streams one frame of 32-bit pixel words from memory to a display through a credit-limited read FIFO.
// Optional IMAGE_BUFFER_READER_ERR_EN adds a sticky err output for read data nobody asked for.
module image_buffer_reader #(
  parameter int N_PIXEL    = 480000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        start_ack,
  input  logic        frame_sel,
  output logic        done,
  input  logic        done_ack,
  output logic [17:0] req_addr,
  output logic        req_valid,
  input  logic        req_ready,
  input  logic [31:0] rdata,
  input  logic        rdata_valid,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
`ifdef IMAGE_BUFFER_READER_ERR_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [16:0] MAX_ADDR = 17'(N_PIXEL / 4 - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic               start_ack_reg, start_ack_r_reg;
  logic               frame_reg;
  logic [16:0]        addr_reg;
  logic [16:0]        pop_cnt_reg;
  logic [CNT_W-1:0]   outstanding_reg;
  logic [CNT_W-1:0]   fifo_count_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic               done_reg;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic start_edge, credit_ok, req_fire, rd_accept, pop, last_pop, restart;

  assign start_edge = start_ack_reg & ~start_ack_r_reg;
  // Reserve a FIFO slot for every request in flight so returning data always fits.
  assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, fifo_count_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign req_fire   = req_valid & req_ready;
  assign rd_accept  = rdata_valid & (outstanding_reg != '0);
  assign dout_valid = (fifo_count_reg != '0);
  assign pop        = dout_valid & dout_ready;
  assign last_pop   = pop & (pop_cnt_reg == MAX_ADDR);
  assign restart    = start_edge & ((state_reg == IDLE) | (state_reg == DONE));

  assign start_ack = start_ack_reg;
  assign done      = done_reg;
  assign req_addr  = {frame_reg, addr_reg};
  assign dout      = fifo_mem[rd_ptr_reg];

  always_comb begin
    state_next = state_reg;
    req_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start_edge) state_next = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        req_valid = credit_ok;
        if (credit_ok && req_ready && addr_reg == MAX_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_pop) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      start_ack_reg   <= 1'b0;
      start_ack_r_reg <= 1'b0;
      frame_reg       <= 1'b0;
      addr_reg        <= '0;
      pop_cnt_reg     <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      start_ack_reg   <= start;
      start_ack_r_reg <= start_ack_reg;
      if (restart) begin
        frame_reg   <= frame_sel;
        addr_reg    <= '0;
        pop_cnt_reg <= '0;
        done_reg    <= 1'b0;
      end else begin
        if (req_fire) addr_reg <= addr_reg + 17'd1;
        if (pop) pop_cnt_reg <= pop_cnt_reg + 17'd1;
        if (state_reg == DRAIN && last_pop) done_reg <= 1'b1;
        else if (done_reg && done_ack) done_reg <= 1'b0;
      end
    end
  end

  // Data arriving with nothing outstanding (e.g. after a mid-frame reset) never enters the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_reg <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      case ({req_fire, rd_accept})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
      case ({rd_accept, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (rd_accept) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)       rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rd_accept) fifo_mem[wr_ptr_reg] <= rdata;
  end

`ifdef IMAGE_BUFFER_READER_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) err <= 1'b0;
    else if (rdata_valid && outstanding_reg == '0) err <= 1'b1;
  end
`endif

endmodule
